fso_deframer: RTL and testbench
===============================

Name: fso_deframer

Overview:
Receive-side counterpart of the FSO TX framer. It consumes the word-aligned 32-bit RX stream and hunts for the 64-bit preamble. It then parses the header, descrambles and forwards exactly PAYLOAD_WORDS payload words downstream, and checks the trailing CRC32. It sits between the RX word aligner and the payload sink or decoder. It reports per-frame status, block/frame indices and error counters.

Parameters:
W, 32, data word width (only 32 supported)
PAYLOAD_WORDS, 16, payload words per frame (≥1)
FRAMES_PER_BLOCK, 255, frames per block; header frame_in_block must be < this

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
i_rx_data  in  32  received word
i_rx_valid  in  1  received word valid
o_rx_ready  out  1  deframer accepts word (rx_fire = i_rx_valid & o_rx_ready)
scrambler_en  in  1  descramble payload (must match TX setting; static per frame)
o_payload_data  out  32  descrambled payload word
o_payload_valid  out  1  payload word valid
o_payload_block_start  out  1  with first payload word of a frame whose header frame_in_block==0
o_payload_last  out  1  with payload word PAYLOAD_WORDS-1
i_payload_ready  in  1  sink ready
o_frame_done  out  1  1-cycle pulse on CRC word accept
o_crc_ok  out  1  CRC result, valid with o_frame_done
o_block_id  out  16  block_id of current/last header
o_frame_in_block  out  16  frame_in_block of current/last header
o_locked  out  1  high after a header is accepted; cleared on hunt
o_frame_ok_cnt  out  16  saturating count of CRC-good frames
o_crc_err_cnt  out  16  saturating count of CRC-bad frames
o_hdr_err_cnt  out  16  saturating count of rejected headers

Behaviour:
- Reset: state=S_HUNT; all outputs, counters and indices 0; o_rx_ready=1 (combinational, not blocked by reset).
- o_rx_ready = i_payload_ready in S_PAYLOAD, 1 in every other state. Nothing advances without rx_fire.
- States and transitions:
  - S_HUNT: on rx_fire with data==32'hEB94_BDA3 -> S_PRE_LO; otherwise stay; o_locked=0.
  - S_PRE_LO: on rx_fire with data==32'hF6AA_EE24 -> S_HEADER. With data==EB94_BDA3, stay in S_PRE_LO (repeated-HI recovery). Any other data -> S_HUNT.
  - S_HEADER: on rx_fire, latch block_id=data[31:16] and frame_in_block=data[15:0].
    - If frame_in_block ≥ FRAMES_PER_BLOCK: hdr_err_cnt++ and go to S_HUNT; the header is not latched to the outputs.
    - Otherwise: latch to o_block_id/o_frame_in_block, set o_locked=1, reset the descrambler and CRC (same cycle, same as TX), clear payload_cnt, and go to S_PAYLOAD.
  - S_PAYLOAD: o_payload_valid=i_rx_valid and o_payload_data=descrambled i_rx_data, both combinational (zero latency).
    - Payload fire = rx_fire. It steps the descrambler (when scrambler_en), updates the CRC with the descrambled word and increments payload_cnt.
    - At payload_cnt==PAYLOAD_WORDS-1, fire -> S_CRC with cnt=0.
    - o_payload_block_start = valid & cnt==0 & o_frame_in_block==0.
    - o_payload_last = valid & cnt==PAYLOAD_WORDS-1.
  - S_CRC: on rx_fire, compare data with crc_out; crc_out is registered and already reflects all payload words.
    - Assert o_frame_done for 1 cycle next clock; o_crc_ok=(match).
    - Increment frame_ok_cnt or crc_err_cnt.
    - Go to S_HUNT.
- Descrambler: same additive scrambler module as TX; scram_rst on header accept; enabled only on payload fire & scrambler_en. With scrambler_en=0, data passes through unchanged.
- CRC: crc32 module over descrambled payload; reset on header accept or !rst_n.
- Counters saturate at 16'hFFFF.
- Backpressure: a payload word held by !i_payload_ready must stay held unchanged; the descrambler and CRC must not step.
- The deframer does not verify block_id/frame_in_block continuity; the sink uses the outputs for that.
- Reset mid-frame: immediate return to S_HUNT; partial payload already forwarded is not retracted; no o_frame_done.

Test Plan:
- Reset, then one frame (block 0, frame 0, scrambler_en=0, payload 1..16, correct CRC) with full-rate valid and ready -> 16 payload words 1..16, block_start on word 1, last on word 16, o_frame_done with o_crc_ok=1, o_frame_ok_cnt=1.
- Same frame with scrambler_en=1 on both TX framer and deframer (loopback) and random i_tx_ready/i_payload_ready stalls -> output equals original payload, no duplicated or dropped words, crc_ok=1.
- CRC word XOR 1 -> o_crc_ok=0, o_crc_err_cnt=1, next frame decoded normally.
- Garbage words, EB94_BDA3, EB94_BDA3, F6AA_EE24, valid frame -> lock on second HI, frame decoded with crc_ok=1.
- Header frame_in_block=255 with FRAMES_PER_BLOCK=255 -> o_hdr_err_cnt=1, no payload valid, return to hunt; the following valid frame decodes.
- rst_n low during payload word 8 -> all outputs 0; the next full frame decodes with crc_ok=1.

Source files
------------

// File: rtl/fso_deframer.sv
// fso_deframer: receive-side FSO frame parser.
//   Hunts for the 64-bit preamble (EB94_BDA3, F6AA_EE24), checks the header,
//   descrambles and forwards PAYLOAD_WORDS payload words with zero latency,
//   then checks the trailing CRC32 word.
// Ports:
//   clk / rst_n            clock, asynchronous active-low reset
//   i_rx_data/valid, o_rx_ready          word-aligned RX stream in
//   scrambler_en                         descramble payload
//   o_payload_* / i_payload_ready        payload stream out
//   o_frame_done / o_crc_ok              per-frame status pulse
//   o_block_id / o_frame_in_block        last accepted header fields
//   o_locked                             header accepted, frame in progress
//   o_frame_ok_cnt / o_crc_err_cnt / o_hdr_err_cnt  saturating counters
// Scrambler: additive PRBS15 (x^15+x^14+1), seed 15'h7FFF, 32 key bits per
//   word, first generated bit lands in key[31].
// CRC32: poly 04C11DB7, MSB-first over each descrambled word, init FFFFFFFF,
//   transmitted value is the bitwise inverse of the register.
module fso_deframer #(
  parameter int W                = 32,
  parameter int PAYLOAD_WORDS    = 16,
  parameter int FRAMES_PER_BLOCK = 255
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] i_rx_data,
  input  logic         i_rx_valid,
  output logic         o_rx_ready,
  input  logic         scrambler_en,
  output logic [W-1:0] o_payload_data,
  output logic         o_payload_valid,
  output logic         o_payload_block_start,
  output logic         o_payload_last,
  input  logic         i_payload_ready,
  output logic         o_frame_done,
  output logic         o_crc_ok,
  output logic [15:0]  o_block_id,
  output logic [15:0]  o_frame_in_block,
  output logic         o_locked,
  output logic [15:0]  o_frame_ok_cnt,
  output logic [15:0]  o_crc_err_cnt,
  output logic [15:0]  o_hdr_err_cnt
);
  localparam logic [31:0] PRE_HI    = 32'hEB94_BDA3;
  localparam logic [31:0] PRE_LO    = 32'hF6AA_EE24;
  localparam logic [31:0] CRC_POLY  = 32'h04C1_1DB7;
  localparam logic [14:0] SCR_SEED  = 15'h7FFF;
  localparam int          CW        = (PAYLOAD_WORDS > 1) ? $clog2(PAYLOAD_WORDS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(PAYLOAD_WORDS - 1);
  localparam logic [16:0] FPB       = 17'(FRAMES_PER_BLOCK);

  typedef enum logic [2:0] {S_HUNT, S_PRE_LO, S_HEADER, S_PAYLOAD, S_CRC} state_t;

  state_t        state;
  logic [14:0]   lfsr, lfsr_nxt;
  logic [31:0]   key, desc;
  logic [31:0]   crc, crc_nxt;
  logic [CW-1:0] cnt;
  logic          fire, in_pay;

  assign in_pay     = (state == S_PAYLOAD);
  assign o_rx_ready = in_pay ? i_payload_ready : 1'b1;
  assign fire       = i_rx_valid & o_rx_ready;

  // Key word for the current LFSR state, and the state 32 steps later.
  always_comb begin
    lfsr_nxt = lfsr;
    key      = '0;
    for (int i = 31; i >= 0; i--) begin
      key[i]   = lfsr_nxt[14] ^ lfsr_nxt[13];
      lfsr_nxt = {lfsr_nxt[13:0], key[i]};
    end
  end

  assign desc = scrambler_en ? (i_rx_data ^ key) : i_rx_data;

  always_comb begin
    crc_nxt = crc;
    for (int i = 31; i >= 0; i--)
      crc_nxt = {crc_nxt[30:0], 1'b0} ^ ({32{crc_nxt[31] ^ desc[i]}} & CRC_POLY);
  end

  // Payload path is combinational so the sink sees the word in the same
  // cycle; backpressure holds the RX word, and nothing steps without fire.
  assign o_payload_valid       = in_pay & i_rx_valid;
  assign o_payload_data        = in_pay ? desc : '0;
  assign o_payload_block_start = o_payload_valid & (cnt == '0) & (o_frame_in_block == 16'd0);
  assign o_payload_last        = o_payload_valid & (cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= S_HUNT;
      lfsr             <= SCR_SEED;
      crc              <= '1;
      cnt              <= '0;
      o_block_id       <= '0;
      o_frame_in_block <= '0;
      o_locked         <= 1'b0;
      o_frame_done     <= 1'b0;
      o_crc_ok         <= 1'b0;
      o_frame_ok_cnt   <= '0;
      o_crc_err_cnt    <= '0;
      o_hdr_err_cnt    <= '0;
    end else begin
      o_frame_done <= 1'b0;
      if (fire) begin
        unique case (state)
          S_HUNT:   if (i_rx_data == PRE_HI) state <= S_PRE_LO;
          S_PRE_LO: begin
            // A repeated HI keeps us waiting for LO rather than re-hunting.
            if (i_rx_data == PRE_LO)      state <= S_HEADER;
            else if (i_rx_data != PRE_HI) state <= S_HUNT;
          end
          S_HEADER: begin
            if ({1'b0, i_rx_data[15:0]} >= FPB) begin
              if (o_hdr_err_cnt != 16'hFFFF) o_hdr_err_cnt <= o_hdr_err_cnt + 16'd1;
              o_locked <= 1'b0;
              state    <= S_HUNT;
            end else begin
              o_block_id       <= i_rx_data[31:16];
              o_frame_in_block <= i_rx_data[15:0];
              o_locked         <= 1'b1;
              lfsr             <= SCR_SEED;
              crc              <= '1;
              cnt              <= '0;
              state            <= S_PAYLOAD;
            end
          end
          S_PAYLOAD: begin
            if (scrambler_en) lfsr <= lfsr_nxt;
            crc <= crc_nxt;
            if (cnt == CNT_LAST) begin
              cnt   <= '0;
              state <= S_CRC;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          S_CRC: begin
            o_frame_done <= 1'b1;
            o_crc_ok     <= (i_rx_data == ~crc);
            if (i_rx_data == ~crc) begin
              if (o_frame_ok_cnt != 16'hFFFF) o_frame_ok_cnt <= o_frame_ok_cnt + 16'd1;
            end else begin
              if (o_crc_err_cnt != 16'hFFFF) o_crc_err_cnt <= o_crc_err_cnt + 16'd1;
            end
            o_locked <= 1'b0;
            state    <= S_HUNT;
          end
          default: state <= S_HUNT;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_fso_deframer.sv
// Directed bench for fso_deframer: the bench plays the TX framer (preamble,
// header, optionally scrambled payload, CRC32) and checks what comes out.
module tb_fso_deframer;
  localparam int PW = 16;
  localparam logic [31:0] HI = 32'hEB94_BDA3;
  localparam logic [31:0] LO = 32'hF6AA_EE24;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] i_rx_data = '0;
  logic        i_rx_valid = 1'b0;
  logic        o_rx_ready;
  logic        scrambler_en = 1'b0;
  logic [31:0] o_payload_data;
  logic        o_payload_valid, o_payload_block_start, o_payload_last;
  logic        i_payload_ready = 1'b1;
  logic        o_frame_done, o_crc_ok, o_locked;
  logic [15:0] o_block_id, o_frame_in_block;
  logic [15:0] o_frame_ok_cnt, o_crc_err_cnt, o_hdr_err_cnt;

  always #5 clk = ~clk;

  fso_deframer #(.W(32), .PAYLOAD_WORDS(PW), .FRAMES_PER_BLOCK(255)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_rx_data(i_rx_data), .i_rx_valid(i_rx_valid), .o_rx_ready(o_rx_ready),
    .scrambler_en(scrambler_en),
    .o_payload_data(o_payload_data), .o_payload_valid(o_payload_valid),
    .o_payload_block_start(o_payload_block_start), .o_payload_last(o_payload_last),
    .i_payload_ready(i_payload_ready),
    .o_frame_done(o_frame_done), .o_crc_ok(o_crc_ok),
    .o_block_id(o_block_id), .o_frame_in_block(o_frame_in_block), .o_locked(o_locked),
    .o_frame_ok_cnt(o_frame_ok_cnt), .o_crc_err_cnt(o_crc_err_cnt), .o_hdr_err_cnt(o_hdr_err_cnt)
  );

  int checks = 0;
  int passed = 0;
  logic stall_en = 1'b0;
  logic [31:0] pl [PW];

  // Monitor: record accepted payload words and frame-done events.
  logic [31:0] got[$];
  int          bs_idx[$];
  int          last_idx[$];
  int          done_cnt = 0;
  logic        last_ok = 1'b0;

  always @(negedge clk) begin
    if (o_payload_valid && i_payload_ready) begin
      if (o_payload_block_start) bs_idx.push_back(got.size());
      if (o_payload_last)        last_idx.push_back(got.size());
      got.push_back(o_payload_data);
    end
    if (o_frame_done) begin
      done_cnt++;
      last_ok = o_crc_ok;
    end
  end

  // Sink backpressure.
  initial forever begin
    @(posedge clk); #1;
    i_payload_ready = stall_en ? ($urandom_range(0, 3) != 0) : 1'b1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // PRBS15 reference kept as a bit history: b[n] = b[n-15] ^ b[n-14].
  bit q[$];
  function automatic void scr_reset();
    q.delete();
    repeat (15) q.push_back(1'b1);
  endfunction
  function automatic logic [31:0] key_word();
    logic [31:0] k = '0;
    for (int i = 0; i < 32; i++) begin
      bit b = q[0] ^ q[1];
      void'(q.pop_front());
      q.push_back(b);
      k = {k[30:0], b};
    end
    return k;
  endfunction

  function automatic logic [31:0] crc_ref();
    logic [31:0] c = 32'hFFFF_FFFF;
    for (int w = 0; w < PW; w++) begin
      c ^= pl[w];
      repeat (32) c = c[31] ? ((c << 1) ^ 32'h04C1_1DB7) : (c << 1);
    end
    return ~c;
  endfunction

  task automatic send(input logic [31:0] d);
    int t = 0;
    if (stall_en && $urandom_range(0, 2) == 0) begin
      i_rx_valid = 1'b0;
      @(posedge clk); #1;
    end
    i_rx_data  = d;
    i_rx_valid = 1'b1;
    @(negedge clk);
    while (!o_rx_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!o_rx_ready) begin
      checks++;
      $error("FAIL rx_timeout: o_rx_ready stuck low for word %h", d);
    end
    @(posedge clk); #1;
    i_rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [15:0] blk, input logic [15:0] fib,
                            input logic scr, input logic [31:0] crc_xor);
    scrambler_en = scr;
    send(HI);
    send(LO);
    send({blk, fib});
    chk("locked_after_hdr", {31'd0, o_locked}, 32'd1);
    scr_reset();
    for (int w = 0; w < PW; w++) begin
      logic [31:0] k = key_word();
      send(scr ? (pl[w] ^ k) : pl[w]);
    end
    send(crc_ref() ^ crc_xor);
  endtask

  task automatic check_frame(input int base, input int bs0, input int l0, input int d0,
                             input logic exp_ok, input logic exp_bs);
    idle(3);
    chk("word_count", got.size() - base, PW);
    for (int w = 0; w < PW; w++) chk($sformatf("word%0d", w), got[base + w], pl[w]);
    chk("block_start_count", bs_idx.size() - bs0, exp_bs ? 1 : 0);
    if (exp_bs) chk("block_start_pos", bs_idx[bs0] - base, 0);
    chk("last_count", last_idx.size() - l0, 1);
    chk("last_pos", last_idx[l0] - base, PW - 1);
    chk("frame_done_count", done_cnt - d0, 1);
    chk("crc_ok", {31'd0, last_ok}, {31'd0, exp_ok});
    chk("locked_after_frame", {31'd0, o_locked}, 32'd0);
  endtask

  int base, bs0, l0, d0;

  task automatic snap();
    base = got.size(); bs0 = bs_idx.size(); l0 = last_idx.size(); d0 = done_cnt;
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_rx_ready", {31'd0, o_rx_ready}, 32'd1);
    chk("rst_locked", {31'd0, o_locked}, 32'd0);
    chk("rst_payload_valid", {31'd0, o_payload_valid}, 32'd0);
    chk("rst_ok_cnt", {16'd0, o_frame_ok_cnt}, 32'd0);
    chk("rst_block_id", {16'd0, o_block_id}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    idle(2);

    // Frame 1: block 0 frame 0, no scrambling, payload 1..16, full rate
    for (int w = 0; w < PW; w++) pl[w] = 32'(w + 1);
    snap();
    send_frame(16'd0, 16'd0, 1'b0, 32'd0);
    check_frame(base, bs0, l0, d0, 1'b1, 1'b1);
    chk("f1_ok_cnt", {16'd0, o_frame_ok_cnt}, 32'd1);
    chk("f1_block_id", {16'd0, o_block_id}, 32'd0);

    // Frame 2: scrambled loopback with source and sink stalls
    for (int w = 0; w < PW; w++) pl[w] = $urandom;
    stall_en = 1'b1;
    snap();
    send_frame(16'd3, 16'd5, 1'b1, 32'd0);
    check_frame(base, bs0, l0, d0, 1'b1, 1'b0);
    stall_en = 1'b0;
    chk("f2_ok_cnt", {16'd0, o_frame_ok_cnt}, 32'd2);
    chk("f2_block_id", {16'd0, o_block_id}, 32'd3);
    chk("f2_frame_in_block", {16'd0, o_frame_in_block}, 32'd5);

    // Frame 3: corrupted CRC, then a clean frame
    snap();
    send_frame(16'd3, 16'd6, 1'b1, 32'd1);
    check_frame(base, bs0, l0, d0, 1'b0, 1'b0);
    chk("f3_crc_err_cnt", {16'd0, o_crc_err_cnt}, 32'd1);
    chk("f3_ok_cnt", {16'd0, o_frame_ok_cnt}, 32'd2);
    snap();
    send_frame(16'd3, 16'd7, 1'b0, 32'd0);
    check_frame(base, bs0, l0, d0, 1'b1, 1'b0);
    chk("f3b_ok_cnt", {16'd0, o_frame_ok_cnt}, 32'd3);

    // Frame 4: garbage, then HI HI LO (lock on second HI)
    for (int w = 0; w < PW; w++) pl[w] = 32'hC0DE_0000 | 32'(w * 7);
    send(32'h1234_5678);
    send(LO);
    send(HI);
    snap();
    send_frame(16'd4, 16'd0, 1'b1, 32'd0);
    check_frame(base, bs0, l0, d0, 1'b1, 1'b1);
    chk("f4_ok_cnt", {16'd0, o_frame_ok_cnt}, 32'd4);
    chk("f4_block_id", {16'd0, o_block_id}, 32'd4);

    // Header with frame_in_block == FRAMES_PER_BLOCK is rejected
    snap();
    send(HI);
    send(LO);
    send({16'd9, 16'd255});
    idle(2);
    chk("hdr_err_cnt", {16'd0, o_hdr_err_cnt}, 32'd1);
    chk("hdr_err_locked", {31'd0, o_locked}, 32'd0);
    chk("hdr_err_block_id", {16'd0, o_block_id}, 32'd4);
    chk("hdr_err_no_payload", got.size() - base, 0);
    snap();
    send_frame(16'd5, 16'd1, 1'b0, 32'd0);
    check_frame(base, bs0, l0, d0, 1'b1, 1'b0);
    chk("f5_ok_cnt", {16'd0, o_frame_ok_cnt}, 32'd5);

    // Reset while payload word 8 is being presented
    scrambler_en = 1'b1;
    send(HI);
    send(LO);
    send({16'd6, 16'd2});
    for (int w = 0; w < 7; w++) send(32'hDEAD_0000 | 32'(w));
    d0 = done_cnt;
    i_rx_data  = 32'hDEAD_0007;
    i_rx_valid = 1'b1;
    @(negedge clk); rst_n = 1'b0;
    #1;
    chk("mid_rst_payload_valid", {31'd0, o_payload_valid}, 32'd0);
    chk("mid_rst_locked", {31'd0, o_locked}, 32'd0);
    chk("mid_rst_block_id", {16'd0, o_block_id}, 32'd0);
    chk("mid_rst_frame_in_block", {16'd0, o_frame_in_block}, 32'd0);
    chk("mid_rst_ok_cnt", {16'd0, o_frame_ok_cnt}, 32'd0);
    chk("mid_rst_hdr_err_cnt", {16'd0, o_hdr_err_cnt}, 32'd0);
    chk("mid_rst_rx_ready", {31'd0, o_rx_ready}, 32'd1);
    @(negedge clk);
    i_rx_valid = 1'b0;
    rst_n = 1'b1;
    idle(3);
    chk("mid_rst_no_done", done_cnt - d0, 0);
    for (int w = 0; w < PW; w++) pl[w] = 32'h5A00_0000 ^ 32'(w * 32'h0101);
    snap();
    send_frame(16'd6, 16'd0, 1'b1, 32'd0);
    check_frame(base, bs0, l0, d0, 1'b1, 1'b1);
    chk("post_rst_ok_cnt", {16'd0, o_frame_ok_cnt}, 32'd1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
